sprite_motion_ctrl: RTL and testbench

Frame-synchronous position controller for the VGA sprite datapath. Takes the four raw move pushbuttons and synchronizes and debounces them. Once per frame, during vertical sync, it computes a new sprite origin. It presents that origin as stable registered coordinates to `vga_controller`, so the pixel pipeline never sees a position change mid-frame. It sits between the board buttons and `vga_controller` in the VGA clock domain.

---
 rtl/sprite_motion_ctrl.sv | 148 ++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite origin controller: debounced buttons, one origin update per vsync.
// Defining SPRITE_WRAP_EN makes the axes wrap around instead of clamping at the edges.
module sprite_motion_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned SPRITE_W  = 32,
  parameter int unsigned SPRITE_H  = 32,
  parameter int unsigned STEP      = 2,
  parameter int unsigned X_INIT    = 304,
  parameter int unsigned Y_INIT    = 224,
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       moveUp,
  input  logic       moveDown,
  input  logic       moveLeft,
  input  logic       moveRight,
  output logic [9:0] oX,
  output logic [8:0] oY,
  output logic       oUpdate,
  output logic       oMoving
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic signed [10:0] XMax  = 11'(H_ACTIVE - SPRITE_W);
  localparam logic signed [10:0] YMax  = 11'(V_ACTIVE - SPRITE_H);
  localparam logic signed [10:0] StepS = 11'(STEP);

  localparam int BtnUp    = 0;
  localparam int BtnDown  = 1;
  localparam int BtnLeft  = 2;
  localparam int BtnRight = 3;

  typedef enum logic [1:0] {S_WAIT, S_CALC, S_COMMIT} state_e;

  state_e            state_q;
  logic [3:0]        btn_raw;
  logic [3:0]        sync1_q, sync2_q, db_q;
  logic [CW-1:0]     cnt_q [4];
  logic              vs_q;
  logic              frame_tick;
  logic signed [10:0] x_cur, y_cur, nx, ny;
  logic [9:0]        nx_q;
  logic [8:0]        ny_q;

  assign btn_raw    = {moveRight, moveLeft, moveDown, moveUp};
  assign frame_tick = vs_q & ~iVS;

  // Two-flop synchronizer, then a per-button stable-level counter.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
            db_q[i]  <= ~db_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Next origin; opposing buttons cancel. STEP <= sprite size keeps one correction enough.
  always_comb begin
    x_cur = signed'({1'b0, oX});
    y_cur = signed'({2'b00, oY});
    nx    = x_cur;
    ny    = y_cur;
    if (db_q[BtnRight] && !db_q[BtnLeft]) begin
      nx = x_cur + StepS;
`ifdef SPRITE_WRAP_EN
      if (nx > XMax) nx = nx - (XMax + 11'sd1);
`else
      if (nx > XMax) nx = XMax;
`endif
    end else if (db_q[BtnLeft] && !db_q[BtnRight]) begin
      nx = x_cur - StepS;
`ifdef SPRITE_WRAP_EN
      if (nx < 11'sd0) nx = nx + XMax + 11'sd1;
`else
      if (nx < 11'sd0) nx = 11'sd0;
`endif
    end
    if (db_q[BtnDown] && !db_q[BtnUp]) begin
      ny = y_cur + StepS;
`ifdef SPRITE_WRAP_EN
      if (ny > YMax) ny = ny - (YMax + 11'sd1);
`else
      if (ny > YMax) ny = YMax;
`endif
    end else if (db_q[BtnUp] && !db_q[BtnDown]) begin
      ny = y_cur - StepS;
`ifdef SPRITE_WRAP_EN
      if (ny < 11'sd0) ny = ny + YMax + 11'sd1;
`else
      if (ny < 11'sd0) ny = 11'sd0;
`endif
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_q <= S_WAIT;
      vs_q    <= 1'b1;
      nx_q    <= '0;
      ny_q    <= '0;
      oX      <= 10'(X_INIT);
      oY      <= 9'(Y_INIT);
      oUpdate <= 1'b0;
      oMoving <= 1'b0;
    end else begin
      vs_q    <= iVS;
      oMoving <= |db_q;
      oUpdate <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (frame_tick) state_q <= S_CALC;
        end
        S_CALC: begin
          nx_q    <= nx[9:0];
          ny_q    <= ny[8:0];
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          oX      <= nx_q;
          oY      <= ny_q;
          oUpdate <= 1'b1;
          state_q <= S_WAIT;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (centred and corner start) against a cycle model.
module tb_sprite_motion_ctrl;

  localparam int DB     = 4;
  localparam int STEP_P = 2;
  localparam int XMAX   = 608;
  localparam int YMAX   = 448;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;

  logic [9:0] ox  [2];
  logic [8:0] oy  [2];
  logic       upd [2];
  logic       mov [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.DB_CYCLES(DB), .STEP(STEP_P)) u_a (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs),
    .moveUp(up), .moveDown(down), .moveLeft(left), .moveRight(right),
    .oX(ox[0]), .oY(oy[0]), .oUpdate(upd[0]), .oMoving(mov[0])
  );

  sprite_motion_ctrl #(.DB_CYCLES(DB), .STEP(STEP_P), .X_INIT(1), .Y_INIT(447)) u_b (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs),
    .moveUp(up), .moveDown(down), .moveLeft(left), .moveRight(right),
    .oX(ox[1]), .oY(oy[1]), .oUpdate(upd[1]), .oMoving(mov[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int move_axis(input int p, input int d, input int lim);
    int n;
    n = p + d * STEP_P;
`ifdef SPRITE_WRAP_EN
    if (n < 0) n += lim + 1;
    else if (n > lim) n -= lim + 1;
`else
    if (n < 0) n = 0;
    else if (n > lim) n = lim;
`endif
    return n;
  endfunction

  // Model: positions, pending update schedule, debounced buttons as run lengths.
  int   init_x [2] = '{304, 1};
  int   init_y [2] = '{224, 447};
  int   mx [2], my [2], tx [2], ty [2];
  bit   mupd, mmov, mvalid = 0;
  bit   mdb [4], p1 [4], p2 [4];
  int   run [4];
  bit   vs_prev;
  longint cyc = 0, calc_at = -1, commit_at = -1, idle_from = 0;

  always @(posedge clk) begin
    bit raw [4];
    bit old_db [4];
    raw = '{up, down, left, right};
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin mx[i] = init_x[i]; my[i] = init_y[i]; end
      for (int b = 0; b < 4; b++) begin mdb[b] = 0; run[b] = 0; p1[b] = 0; p2[b] = 0; end
      mupd = 0; mmov = 0; vs_prev = 1;
      calc_at = -1; commit_at = -1; idle_from = 0;
      mvalid = 1;
    end else begin
      old_db = mdb;
      for (int b = 0; b < 4; b++) begin
        if (p2[b] != mdb[b]) begin
          run[b]++;
          if (run[b] == DB) begin mdb[b] = ~mdb[b]; run[b] = 0; end
        end else run[b] = 0;
        p2[b] = p1[b];
        p1[b] = raw[b];
      end
      mmov = old_db[0] | old_db[1] | old_db[2] | old_db[3];
      mupd = 0;
      if (cyc == calc_at) begin
        for (int i = 0; i < 2; i++) begin
          tx[i] = move_axis(mx[i], int'(old_db[3]) - int'(old_db[2]), XMAX);
          ty[i] = move_axis(my[i], int'(old_db[1]) - int'(old_db[0]), YMAX);
        end
      end
      if (cyc == commit_at) begin
        for (int i = 0; i < 2; i++) begin mx[i] = tx[i]; my[i] = ty[i]; end
        mupd = 1;
      end
      if (!vs && vs_prev && cyc >= idle_from) begin
        calc_at = cyc + 1; commit_at = cyc + 2; idle_from = cyc + 3;
      end
      vs_prev = vs;
    end
  end

  int upd_cnt = 0;

  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        chk("cyc_x", 32'(ox[i]), 32'(mx[i]));
        chk("cyc_y", 32'(oy[i]), 32'(my[i]));
        chk("cyc_upd", 32'(upd[i]), 32'(mupd));
        chk("cyc_mov", 32'(mov[i]), 32'(mmov));
      end
      if (upd[0] === 1'b1) upd_cnt++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk) vs = 1'b0;
    wait_neg(5);
    vs = 1'b1;
    wait_neg(5);
  endtask

  initial begin
    int base;
    wait_neg(3);
    rst_n = 1'b1;
    chk("rst_x", 32'(ox[0]), 304);
    chk("rst_y", 32'(oy[0]), 224);
    chk("rst_upd", 32'(upd[0]), 0);
    chk("rst_mov", 32'(mov[0]), 0);
    chk("rst_bx", 32'(ox[1]), 1);
    chk("rst_by", 32'(oy[1]), 447);

    base = upd_cnt;
    repeat (3) frame();
    chk("idle_updates", 32'(upd_cnt - base), 3);
    chk("idle_x", 32'(ox[0]), 304);

    // Corner instance: left + down against the edges.
    left = 1'b1; down = 1'b1;
    wait_neg(10);
    frame();
`ifdef SPRITE_WRAP_EN
    chk("edge_x1", 32'(ox[1]), 608);
    chk("edge_y1", 32'(oy[1]), 0);
`else
    chk("edge_x1", 32'(ox[1]), 0);
    chk("edge_y1", 32'(oy[1]), 448);
`endif
    repeat (2) frame();
`ifdef SPRITE_WRAP_EN
    chk("edge_x3", 32'(ox[1]), 604);
    chk("edge_y3", 32'(oy[1]), 4);
`else
    chk("edge_x3", 32'(ox[1]), 0);
    chk("edge_y3", 32'(oy[1]), 448);
`endif

    left = 1'b0; down = 1'b0;
    rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);

    right = 1'b1;
    wait_neg(10);
    chk("right_mov", 32'(mov[0]), 1);
    repeat (10) frame();
    chk("right_x", 32'(ox[0]), 324);
    chk("right_y", 32'(oy[0]), 224);
    chk("right_mov2", 32'(mov[0]), 1);

    up = 1'b1; down = 1'b1;
    wait_neg(10);
    repeat (3) frame();
    chk("cancel_x", 32'(ox[0]), 330);
    chk("cancel_y", 32'(oy[0]), 224);

    up = 1'b0; down = 1'b0; right = 1'b0;
    wait_neg(10);
    chk("release_mov", 32'(mov[0]), 0);
    @(negedge clk) left = 1'b1;
    wait_neg(3);
    left = 1'b0;
    wait_neg(10);
    chk("glitch_mov", 32'(mov[0]), 0);
    frame();
    chk("glitch_x", 32'(ox[0]), 330);

    // Reset landing on the S_CALC edge must abort the update.
    @(negedge clk) vs = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin rst_n = 1'b1; vs = 1'b1; end
    base = upd_cnt;
    @(negedge clk);
    chk("abort_upd", 32'(upd[0]), 0);
    chk("abort_x", 32'(ox[0]), 304);
    chk("abort_y", 32'(oy[0]), 224);
    wait_neg(4);
    frame();
    chk("after_abort_updates", 32'(upd_cnt - base), 1);
    chk("after_abort_x", 32'(ox[0]), 304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
